// File: rtl/vecgen_row_packer_if.sv
// Bus bundle for the row packer: buffer read port plus PE write port.
//
// Handshakes: a read word transfers on any cycle where read_req && read_ready;
// its data returns with read_data_v exactly one cycle later. A write vector
// transfers on any cycle where write_valid && write_ready; while write_valid
// is high and write_ready is low, write_data/write_mask stay frozen.
interface vecgen_row_packer_if #(
  parameter int OP_WIDTH = 16,
  parameter int NUM_PE   = 4,
  parameter int RD_WIDTH = 64
);
  logic                       read_req;
  logic                       read_ready;
  logic [RD_WIDTH-1:0]        read_data;
  logic                       read_data_v;
  logic [NUM_PE*OP_WIDTH-1:0] write_data;
  logic [NUM_PE-1:0]          write_mask;
  logic                       write_valid;
  logic                       write_ready;

  // Packer side
  modport master (
    output read_req,
    input  read_ready, read_data, read_data_v,
    output write_data, write_mask, write_valid,
    input  write_ready
  );

  // Buffer / PE side
  modport slave (
    input  read_req,
    output read_ready, read_data, read_data_v,
    input  write_data, write_mask, write_valid,
    output write_ready
  );
endinterface

// File: rtl/vecgen_row_packer.sv
// Streams one padded IFM row from the read buffer into NUM_PE-wide PE
// write vectors. Padding zeros are generated on the fly; only real row
// operands pass through the staging buffer.
module vecgen_row_packer #(
  parameter int OP_WIDTH          = 16,
  parameter int NUM_PE            = 4,
  parameter int RD_WIDTH          = 64,
  parameter int PAD_WIDTH         = 3,
  parameter int LAYER_PARAM_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [LAYER_PARAM_WIDTH-1:0] cfg_row_width,
  input  logic [PAD_WIDTH-1:0]         cfg_pad,
  output logic                         ready,
  output logic                         row_done,
  output logic [1:0]                   dbg_state_o,
  vecgen_row_packer_if.master          bus
);
  localparam int OPS = RD_WIDTH / OP_WIDTH;
  localparam int STG = 2 * NUM_PE;
  localparam int CW  = $clog2(STG + 1);
  localparam int EW  = ((LAYER_PARAM_WIDTH > PAD_WIDTH) ? LAYER_PARAM_WIDTH : PAD_WIDTH) + 3;
  localparam int VW  = NUM_PE * OP_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q;
  logic                ready_q, row_done_q;
  logic [EW-1:0]       pad_q, wid_q, nvec_q, vec_idx_q, words_left_q, ops_left_q;
  logic [1:0]          inflight_q, inflight_d;
  logic [CW-1:0]       count_q, count_d;
  logic [OP_WIDTH-1:0] stage_q [STG];
  logic [OP_WIDTH-1:0] stage_d [STG];
  logic [VW-1:0]       wdata_q;
  logic [NUM_PE-1:0]   wmask_q;
  logic                wvalid_q;

  logic                start_acc, read_req_c, xfer, rdv_ok, load_en, more_vec;
  logic [EW-1:0]       p_e, w_e, n_e, vidx_e, base_e, e;
  logic [CW-1:0]       need, pop_n, push_n, base;
  logic [VW-1:0]       vec_data;
  logic [NUM_PE-1:0]   vec_mask;

  // Next vector assembly, read request gating and staging shift/fill.
  always_comb begin
    start_acc = start && ready_q;
    // While idle the first vector is built straight from cfg so a
    // padding-only vector can be loaded in the start cycle.
    if (state_q == S_IDLE) begin
      p_e    = EW'(cfg_pad);
      w_e    = EW'(cfg_row_width);
      vidx_e = '0;
    end else begin
      p_e    = pad_q;
      w_e    = wid_q;
      vidx_e = vec_idx_q;
    end
    n_e      = (p_e << 1) + w_e;
    base_e   = vidx_e * EW'(NUM_PE);
    more_vec = (state_q == S_IDLE) ? (n_e != '0) : (vec_idx_q < nvec_q);

    // Lanes past the row end are unmasked zeros; pad lanes are masked zeros;
    // row lanes consume staging entries in order from the head.
    e        = '0;
    need     = '0;
    vec_data = '0;
    vec_mask = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      e = base_e + EW'(i);
      if (e < n_e) begin
        vec_mask[i] = 1'b1;
        if (e >= p_e && e < p_e + w_e) begin
          for (int j = 0; j < NUM_PE; j++) begin
            if (need == CW'(j)) vec_data[i*OP_WIDTH +: OP_WIDTH] = stage_q[j];
          end
          need = need + CW'(1);
        end
      end
    end

    load_en = ((state_q == S_RUN) || start_acc) && (!wvalid_q || bus.write_ready) &&
              more_vec && (count_q >= need);
    pop_n   = load_en ? need : '0;

    // Request only when every word already in flight plus this one still fits.
    read_req_c = (state_q == S_RUN) && (words_left_q != '0) &&
                 ((32'(STG) - 32'(count_q)) >= 32'(OPS) * (32'd1 + 32'(inflight_q)));
    xfer       = read_req_c && bus.read_ready;
    rdv_ok     = bus.read_data_v && (inflight_q != 2'd0);
    push_n     = '0;
    if (rdv_ok) push_n = (ops_left_q >= EW'(OPS)) ? CW'(OPS) : CW'(ops_left_q);

    count_d    = count_q - pop_n + push_n;
    inflight_d = inflight_q + 2'(xfer) - 2'(rdv_ok);

    // Shift out consumed ops, then append the returned word's useful ops.
    base = count_q - pop_n;
    for (int j = 0; j < STG; j++) begin
      stage_d[j] = stage_q[j];
      for (int p = 1; p <= NUM_PE; p++) begin
        if (pop_n == CW'(p) && (j + p) < STG) stage_d[j] = stage_q[(j + p) % STG];
      end
      for (int t = 0; t < OPS; t++) begin
        if (CW'(t) < push_n && (base + CW'(t)) == CW'(j))
          stage_d[j] = bus.read_data[t*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  // Row FSM together with staging, read bookkeeping and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      row_done_q   <= 1'b0;
      pad_q        <= '0;
      wid_q        <= '0;
      nvec_q       <= '0;
      vec_idx_q    <= '0;
      words_left_q <= '0;
      ops_left_q   <= '0;
      inflight_q   <= '0;
      count_q      <= '0;
      for (int j = 0; j < STG; j++) stage_q[j] <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wvalid_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stage_q    <= stage_d;
      if (xfer)   words_left_q <= words_left_q - EW'(1);
      if (rdv_ok) ops_left_q   <= ops_left_q - EW'(push_n);
      if (load_en) begin
        wdata_q   <= vec_data;
        wmask_q   <= vec_mask;
        wvalid_q  <= 1'b1;
        vec_idx_q <= vidx_e + EW'(1);
      end else if (wvalid_q && bus.write_ready) begin
        wdata_q  <= '0;
        wmask_q  <= '0;
        wvalid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            pad_q        <= p_e;
            wid_q        <= w_e;
            nvec_q       <= (n_e + EW'(NUM_PE - 1)) / EW'(NUM_PE);
            words_left_q <= (w_e + EW'(OPS - 1)) / EW'(OPS);
            ops_left_q   <= w_e;
            ready_q      <= 1'b0;
            if (!load_en) vec_idx_q <= '0;
            if (n_e == '0) begin
              state_q    <= S_DONE;
              row_done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (wvalid_q && bus.write_ready && vec_idx_q == nvec_q) begin
            state_q    <= S_DONE;
            row_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          row_done_q <= 1'b0;
          ready_q    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready           = ready_q;
  assign row_done        = row_done_q;
  assign dbg_state_o     = state_q;
  assign bus.read_req    = read_req_c;
  assign bus.write_data  = wdata_q;
  assign bus.write_mask  = wmask_q;
  assign bus.write_valid = wvalid_q;
endmodule
